// File: rtl/menu_pkg.sv
// Shared constants for the select-mode menu: FSM encoding, game modes and
// row geometry (the renderer uses the same row offsets).
package menu_pkg;

    localparam logic [1:0] ST_MENU  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

    localparam logic MODE_SCORE = 1'b0;
    localparam logic MODE_TIME  = 1'b1;

    localparam int MENU_Y_DEFAULT = 100;
    localparam int ROW_OFF_SCORE  = 130;
    localparam int ROW_OFF_TIME   = 210;

    function automatic logic [9:0] row_y(input int menu_y, input int row_off);
        return 10'(menu_y + row_off);
    endfunction

endpackage

// File: rtl/menu_mode_ctrl_if.sv
// Player-button, game-core and renderer signals of the menu controller.
interface menu_mode_ctrl_if;

    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       game_over;
    logic       mode;
    logic [9:0] cursor_y;
    logic       cursor_on;
    logic       menu_active;
    logic       start_game;

    modport master (
        output frame_tick, btn_up, btn_down, btn_enter, game_over,
        input  mode, cursor_y, cursor_on, menu_active, start_game
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_enter, game_over,
        output mode, cursor_y, cursor_on, menu_active, start_game
    );

endinterface

// File: rtl/btn_debounce.sv
// Raw button conditioning: two-flop synchroniser, stability counter and a
// registered rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_dly_q;
    logic             press_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the synchroniser into a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            fill_q      <= {fill_q[0], 1'b1};
            level_dly_q <= level_q;

            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // A button held through reset must be seen released before it
            // may produce a press.
            if (fill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end

            press_q <= armed_q & level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/menu_mode_ctrl.sv
// Select-mode menu controller: debounced cursor movement between SCORE and
// TIME rows, mode latch, start strobe and cursor blink.
module menu_mode_ctrl
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MENU_Y          = MENU_Y_DEFAULT,
    parameter int SCORE_ROW_OFF   = ROW_OFF_SCORE,
    parameter int TIME_ROW_OFF    = ROW_OFF_TIME,
    parameter int BLINK_FRAMES    = 30
) (
    input logic             clk,
    input logic             reset,
    menu_mode_ctrl_if.slave bus
);

    localparam logic [9:0]         SCORE_Y    = row_y(MENU_Y, SCORE_ROW_OFF);
    localparam logic [9:0]         TIME_Y     = row_y(MENU_Y, TIME_ROW_OFF);
    localparam int                 BLINK_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic       up_evt, down_evt, enter_evt;
    logic [2:0] level_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .raw(bus.btn_up),
        .level(level_unused[0]), .press(up_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .raw(bus.btn_down),
        .level(level_unused[1]), .press(down_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk(clk), .reset(reset), .raw(bus.btn_enter),
        .level(level_unused[2]), .press(enter_evt)
    );

    logic [1:0]         state_q, state_d;
    logic               mode_q, mode_d;
    logic [9:0]         cursor_y_q, cursor_y_d;
    logic               cursor_on_q, cursor_on_d;
    logic               menu_active_q, menu_active_d;
    logic               start_game_q, start_game_d;
    logic [BLINK_W-1:0] blink_q, blink_d;

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cursor_on_d   = cursor_on_q;
        menu_active_d = menu_active_q;
        start_game_d  = 1'b0;
        blink_d       = blink_q;

        case (state_q)
            ST_MENU: begin
                if (enter_evt) begin
                    state_d      = ST_START;
                    start_game_d = 1'b1;
                end else if (up_evt ^ down_evt) begin
                    mode_d      = down_evt ? MODE_TIME : MODE_SCORE;
                    cursor_on_d = 1'b1;
                    blink_d     = '0;
                end else if (bus.frame_tick) begin
                    if (blink_q == BLINK_LAST) begin
                        blink_d     = '0;
                        cursor_on_d = ~cursor_on_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d       = ST_PLAY;
                menu_active_d = 1'b0;
                cursor_on_d   = 1'b0;
            end
            ST_PLAY: begin
                if (bus.game_over) begin
                    state_d       = ST_MENU;
                    menu_active_d = 1'b1;
                    cursor_on_d   = 1'b1;
                    blink_d       = '0;
                end
            end
            default: begin
                state_d       = ST_MENU;
                menu_active_d = 1'b1;
            end
        endcase

        cursor_y_d = (mode_d == MODE_TIME) ? TIME_Y : SCORE_Y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_MENU;
            mode_q        <= MODE_SCORE;
            cursor_y_q    <= SCORE_Y;
            cursor_on_q   <= 1'b1;
            menu_active_q <= 1'b1;
            start_game_q  <= 1'b0;
            blink_q       <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cursor_y_q    <= cursor_y_d;
            cursor_on_q   <= cursor_on_d;
            menu_active_q <= menu_active_d;
            start_game_q  <= start_game_d;
            blink_q       <= blink_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.cursor_y    = cursor_y_q;
    assign bus.cursor_on   = cursor_on_q;
    assign bus.menu_active = menu_active_q;
    assign bus.start_game  = start_game_q;

endmodule
